stream_prefetcher: RTL and testbench
====================================

# stream_prefetcher

Sequential next-line stream prefetcher that initiates prefetch requests toward the prefetch executor. It trains on demand-access observations from the load pipeline, detects ascending line streams, and issues one line-address prefetch at a time over the Prefetch valid/ready interface. It then consumes the matching Prefetch_ACK, and enforces a timeout because the executor silently drops requests when its miss path is busy.

## Interface
Parameters:
- DEGREE, 4: max lines the prefetch pointer may run ahead of the latest demand line (1..15)
- ACK_TIMEOUT, 8: cycles after accept before an outstanding request counts as dropped (>=4)
- MAX_RETRY, 1: reissues of a timed-out line before the stream is abandoned
- USELESS_LIMIT, 4: consecutive existing=1 acks that abandon the stream

Ports (clock and reset first):
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- IN_access  in  PFTrain  demand observation {addr[31:0], miss, valid}
- IN_flush  in  1  abandon stream and any outstanding request
- OUT_prefetch  out  Prefetch  request {addr[31:0], valid}
- IN_prefetchReady  in  1  executor accepts OUT_prefetch this cycle
- IN_prefetchAck  in  Prefetch_ACK  {existing, valid} completion from executor
- OUT_busy  out  1  state != IDLE
- OUT_statIssued, OUT_statExisting, OUT_statTimeout  out  32 each  stats counters

## Operation
- Line address L = addr[31:`CLSIZE_E]. Prefetch addr = {P, `CLSIZE_E'b0}. Page = addr[31:12].
- States: IDLE, TRAIN, ISSUE, WAIT_ACK.
- IDLE: a valid demand miss loads lastMiss=L and moves to TRAIN.
- TRAIN: a valid miss with L==lastMiss+1 sets demandLine=L, P=L+1, retry=0, useless=0, and moves to ISSUE. Any other miss overwrites lastMiss. Hits are ignored.
- ISSUE: OUT_prefetch.valid=1 with addr from P. On valid&&ready, move to WAIT_ACK, clear the timer, and increment statIssued.
- ISSUE, throttle: if P-demandLine > DEGREE (4-bit modular difference), hold valid=0 in ISSUE until demand catches up.
- ISSUE, page bound: if P crosses the page of demandLine, move to IDLE. This also covers 32-bit wrap.
- WAIT_ACK, ack existing=0: P=P+1, useless=0, retry=0, go to ISSUE.
- WAIT_ACK, ack existing=1: P=P+1, useless++, statExisting++. Reaching USELESS_LIMIT goes to IDLE, otherwise to ISSUE.
- WAIT_ACK, timer reaches ACK_TIMEOUT: statTimeout++. If retry<MAX_RETRY, retry++ and reissue the same P from ISSUE; otherwise go to IDLE.
- Acks outside WAIT_ACK are ignored (late acks after flush, reset, or timeout).
- Any state except IDLE/TRAIN: a valid access (hit or miss) with demandLine < L <= P updates demandLine=L. A miss outside [demandLine, P] moves to TRAIN with lastMiss=L. In WAIT_ACK this abandons the outstanding request, and any later ack is ignored.
- IN_flush: move to IDLE next cycle and drop valid. Flush has priority over access and ack in the same cycle.
- Same-cycle access + ack: both apply. The demandLine update and P advance use pre-cycle values.

## Timing
- OUT_prefetch is registered. valid stays asserted and addr stays stable until the valid&&ready cycle. valid deasserts the cycle after accept.
- The executor acks exactly 3 cycles after accept, or never. The timer counts from the accept cycle, so timeout fires at accept+ACK_TIMEOUT.
- Best-case throughput: one request per 5 cycles (accept, 3 wait cycles, ack → ISSUE, re-assert).
- Reset values: state=IDLE, OUT_prefetch.valid=0, OUT_busy=0, stats=0, counters=0.
- Reset mid-WAIT_ACK discards the request, and the later ack is ignored.

## Configuration
- PF_STATS_EN defined: the three 32-bit saturating stat counters are implemented.
- PF_STATS_EN undefined: counter logic is omitted, and OUT_stat* are constant 0. Ports remain.

## Structure
- Shared package holds PFTrain, the existing Prefetch and Prefetch_ACK, and the PFState enum.
- `CLSIZE_E comes from the global config header.
- One natural sub-module: pf_ack_timer (counter with start/clear/expire). Everything else stays inline.

## Test plan
- Stream start: misses at 0x1000 then 0x1040, ready=1, ack existing=0 after 3 cycles → requests 0x1080, 0x10C0, 0x1100, 0x1140, then stall (DEGREE=4). A hit at 0x1080 releases 0x1180.
- Drop/retry: hold ack off after accepting 0x1080 → statTimeout=1 at accept+8 and 0x1080 is reissued. A second drop → IDLE, OUT_busy=0.
- Useless: four consecutive existing=1 acks → IDLE after the 4th, statExisting=4.
- Page bound: train on 0x1F80, 0x1FC0 → no request for 0x2000, state IDLE.
- Retrain/flush: an off-stream miss at 0x8000 in WAIT_ACK → TRAIN, and the late ack is ignored (P unchanged). Flush + ack in the same cycle → IDLE.
- Reset while valid=1 and ready=0 → valid=0 next cycle, all stats 0.

Source files
------------

// File: rtl/stream_prefetcher_pkg.sv
// Shared types, sizing constants and helpers for the stream prefetcher.
// CLSIZE_E (log2 of cache-line bytes) normally comes from the global config header.
`ifndef CLSIZE_E
`define CLSIZE_E 6
`endif

package stream_prefetcher_pkg;

  localparam int CLSIZE_E = `CLSIZE_E;
  localparam int LINE_W   = 32 - CLSIZE_E;
  localparam int PAGE_LSB = 12 - CLSIZE_E;

  typedef struct packed {
    logic [31:0] addr;
    logic        miss;
    logic        valid;
  } PFTrain;

  typedef struct packed {
    logic [31:0] addr;
    logic        valid;
  } Prefetch;

  typedef struct packed {
    logic existing;
    logic valid;
  } Prefetch_ACK;

  typedef enum logic [1:0] {
    IDLE,
    TRAIN,
    ISSUE,
    WAIT_ACK
  } PFState;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int clogb(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_prefetcher_ack_timer.sv
// pf_ack_timer: counts cycles since a prefetch was accepted; o_expire holds once TIMEOUT is reached.
module pf_ack_timer
  import stream_prefetcher_pkg::*;
#(
  parameter int TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_clear,
  output logic o_expire
);

  localparam int CW = clogb(TIMEOUT + 1);

  logic [CW-1:0] r_count;
  logic          r_running;

  // Starting at 1 makes the count equal to cycles elapsed since the accept edge.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count   <= '0;
      r_running <= 1'b0;
    end else if (i_start) begin
      r_count   <= CW'(1);
      r_running <= 1'b1;
    end else if (r_running && !o_expire) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_expire = r_running && (r_count == CW'(TIMEOUT));

endmodule

// File: rtl/stream_prefetcher.sv
// stream_prefetcher: ascending next-line stream prefetcher with ack timeout and retry.
// Optional build macro PF_STATS_EN enables the saturating issued/existing/timeout counters.
module stream_prefetcher
  import stream_prefetcher_pkg::*;
#(
  parameter int DEGREE        = 4,
  parameter int ACK_TIMEOUT   = 8,
  parameter int MAX_RETRY     = 1,
  parameter int USELESS_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  PFTrain      IN_access,
  input  logic        IN_flush,
  output Prefetch     OUT_prefetch,
  input  logic        IN_prefetchReady,
  input  Prefetch_ACK IN_prefetchAck,
  output logic        OUT_busy,
  output logic [31:0] OUT_statIssued,
  output logic [31:0] OUT_statExisting,
  output logic [31:0] OUT_statTimeout
);

  localparam int RW = clogb(MAX_RETRY + 1);
  localparam int UW = clogb(USELESS_LIMIT + 1);

  PFState              r_state, w_state;
  logic [LINE_W-1:0]   r_lastMiss, w_lastMiss;
  logic [LINE_W-1:0]   r_demandLine, w_demandLine;
  logic [LINE_W-1:0]   r_P, w_P;
  logic [RW-1:0]       r_retry, w_retry;
  logic [UW-1:0]       r_useless, w_useless;
  logic                r_pfValid, w_pfValid;

  logic [LINE_W-1:0]   w_accLine;
  logic                w_accMiss, w_inWindow, w_offStream;
  logic                w_accept, w_pageCross, w_expire, w_timerClear;
  logic [3:0]          w_diffNext;
  logic                w_incIssued, w_incExisting, w_incTimeout;
  logic                w_unusedAddr;

  assign w_accLine    = IN_access.addr[31:CLSIZE_E];
  assign w_unusedAddr = ^IN_access.addr[CLSIZE_E-1:0];
  assign w_accMiss    = IN_access.valid && IN_access.miss;
  assign w_inWindow   = (w_accLine > r_demandLine) && (w_accLine <= r_P);
  assign w_offStream  = w_accMiss && ((w_accLine < r_demandLine) || (w_accLine > r_P));
  assign w_accept     = r_pfValid && IN_prefetchReady;
  assign w_pageCross  = r_P[LINE_W-1:PAGE_LSB] != r_demandLine[LINE_W-1:PAGE_LSB];

  always_comb begin
    w_state       = r_state;
    w_lastMiss    = r_lastMiss;
    w_demandLine  = r_demandLine;
    w_P           = r_P;
    w_retry       = r_retry;
    w_useless     = r_useless;
    w_incIssued   = 1'b0;
    w_incExisting = 1'b0;
    w_incTimeout  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accMiss) begin
          w_lastMiss = w_accLine;
          w_state    = TRAIN;
        end
      end
      TRAIN: begin
        if (w_accMiss) begin
          if (w_accLine == r_lastMiss + LINE_W'(1)) begin
            w_demandLine = w_accLine;
            w_P          = w_accLine + LINE_W'(1);
            w_retry      = '0;
            w_useless    = '0;
            w_state      = ISSUE;
          end else begin
            w_lastMiss = w_accLine;
          end
        end
      end
      ISSUE, WAIT_ACK: begin
        // An off-stream miss retrains and abandons whatever is outstanding.
        if (w_offStream) begin
          w_lastMiss = w_accLine;
          w_state    = TRAIN;
        end else begin
          if (IN_access.valid && w_inWindow) w_demandLine = w_accLine;
          if (r_state == ISSUE) begin
            if (w_pageCross) begin
              w_state = IDLE;
            end else if (w_accept) begin
              w_state     = WAIT_ACK;
              w_incIssued = 1'b1;
            end
          end else if (IN_prefetchAck.valid) begin
            w_P = r_P + LINE_W'(1);
            if (IN_prefetchAck.existing) begin
              w_useless     = r_useless + UW'(1);
              w_incExisting = 1'b1;
              w_state       = (r_useless + UW'(1) == UW'(USELESS_LIMIT)) ? IDLE : ISSUE;
            end else begin
              w_useless = '0;
              w_retry   = '0;
              w_state   = ISSUE;
            end
          end else if (w_expire) begin
            w_incTimeout = 1'b1;
            if (r_retry < RW'(MAX_RETRY)) begin
              w_retry = r_retry + RW'(1);
              w_state = ISSUE;
            end else begin
              w_state = IDLE;
            end
          end
        end
      end
      default: w_state = IDLE;
    endcase
    if (IN_flush) begin
      w_state       = IDLE;
      w_incIssued   = 1'b0;
      w_incExisting = 1'b0;
      w_incTimeout  = 1'b0;
    end
  end

  // Valid re-asserts one cycle after entering ISSUE, giving the 5-cycle best-case cadence.
  assign w_diffNext = w_P[3:0] - w_demandLine[3:0];
  assign w_pfValid  = (r_state == ISSUE) && (w_state == ISSUE) && !w_accept &&
                      (w_diffNext <= 4'(DEGREE)) &&
                      (w_P[LINE_W-1:PAGE_LSB] == w_demandLine[LINE_W-1:PAGE_LSB]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_lastMiss   <= '0;
      r_demandLine <= '0;
      r_P          <= '0;
      r_retry      <= '0;
      r_useless    <= '0;
      r_pfValid    <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_lastMiss   <= w_lastMiss;
      r_demandLine <= w_demandLine;
      r_P          <= w_P;
      r_retry      <= w_retry;
      r_useless    <= w_useless;
      r_pfValid    <= w_pfValid;
    end
  end

  assign w_timerClear = IN_flush || ((r_state == WAIT_ACK) && (w_state != WAIT_ACK));

  pf_ack_timer #(.TIMEOUT(ACK_TIMEOUT)) u_ackTimer (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_accept),
    .i_clear  (w_timerClear),
    .o_expire (w_expire)
  );

  assign OUT_prefetch.addr  = {r_P, {CLSIZE_E{1'b0}}};
  assign OUT_prefetch.valid = r_pfValid;
  assign OUT_busy           = (r_state != IDLE);

`ifdef PF_STATS_EN
  logic [31:0] r_statIssued, r_statExisting, r_statTimeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_statIssued   <= '0;
      r_statExisting <= '0;
      r_statTimeout  <= '0;
    end else begin
      if (w_incIssued && (r_statIssued != '1))     r_statIssued   <= r_statIssued + 32'd1;
      if (w_incExisting && (r_statExisting != '1)) r_statExisting <= r_statExisting + 32'd1;
      if (w_incTimeout && (r_statTimeout != '1))   r_statTimeout  <= r_statTimeout + 32'd1;
    end
  end

  assign OUT_statIssued   = r_statIssued;
  assign OUT_statExisting = r_statExisting;
  assign OUT_statTimeout  = r_statTimeout;
`else
  logic w_unusedStats;
  assign w_unusedStats    = ^{w_incIssued, w_incExisting, w_incTimeout};
  assign OUT_statIssued   = '0;
  assign OUT_statExisting = '0;
  assign OUT_statTimeout  = '0;
`endif

endmodule

// File: tb/tb_stream_prefetcher.sv
// Self-checking bench for stream_prefetcher: a per-cycle vector table for stream start/throttle,
// plus directed sequences for retry, useless acks, page bound, retrain, flush and reset.
module tb_stream_prefetcher;
  import stream_prefetcher_pkg::*;

`ifdef PF_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam int NUM_VECS = 29;

  typedef struct {
    logic        accValid;
    logic        accMiss;
    logic [31:0] accAddr;
    logic        ackValid;
    logic        flush;
    logic        expValid;
    logic [31:0] expAddr;
    logic        expBusy;
  } TestVector;

  logic        clk = 1'b0;
  logic        rst;
  PFTrain      access;
  logic        flush;
  Prefetch     pf;
  logic        ready;
  Prefetch_ACK ack;
  logic        busy;
  logic [31:0] statIssued, statExisting, statTimeout;

  int checks   = 0;
  int failures = 0;

  TestVector vecs[NUM_VECS];

  always #5 clk = ~clk;

  stream_prefetcher #(
    .DEGREE(4), .ACK_TIMEOUT(8), .MAX_RETRY(1), .USELESS_LIMIT(4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .IN_access        (access),
    .IN_flush         (flush),
    .OUT_prefetch     (pf),
    .IN_prefetchReady (ready),
    .IN_prefetchAck   (ack),
    .OUT_busy         (busy),
    .OUT_statIssued   (statIssued),
    .OUT_statExisting (statExisting),
    .OUT_statTimeout  (statTimeout)
  );

  function automatic logic [31:0] expStat(input int n);
    return STATS ? 32'(n) : 32'd0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the clock edge.
  task automatic applyStimulus(input logic accValid, input logic accMiss, input logic [31:0] accAddr,
                               input logic rdy, input logic ackValid, input logic ackExisting,
                               input logic fl);
    access.valid = accValid;
    access.miss  = accMiss;
    access.addr  = accAddr;
    ready        = rdy;
    ack.valid    = ackValid;
    ack.existing = ackExisting;
    flush        = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic missAt(input logic [31:0] addr);
    applyStimulus(1'b1, 1'b1, addr, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic resetDut();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic waitValid(input string name, input logic [31:0] expAddr);
    for (int i = 0; i < 12 && !pf.valid; i++) idle(1);
    checkOutput({name, " valid"}, 32'(pf.valid), 32'd1);
    checkOutput({name, " addr"}, pf.addr, expAddr);
  endtask

  // Wait for a request, accept it, and answer three cycles later (or stay silent).
  task automatic doRequest(input string name, input logic [31:0] expAddr,
                           input logic ackOn, input logic existing);
    waitValid(name, expAddr);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput({name, " valid after accept"}, 32'(pf.valid), 32'd0);
    idle(2);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, ackOn, existing, 1'b0);
  endtask

  task automatic setAccess(input int idx, input logic miss, input logic [31:0] addr);
    vecs[idx].accValid = 1'b1;
    vecs[idx].accMiss  = miss;
    vecs[idx].accAddr  = addr;
  endtask

  task automatic setExp(input int idx, input logic [31:0] addr);
    vecs[idx].expValid = 1'b1;
    vecs[idx].expAddr  = addr;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Stream start with ready held high: one row per cycle.
    for (int i = 0; i < NUM_VECS; i++)
      vecs[i] = '{accValid: 1'b0, accMiss: 1'b0, accAddr: 32'h0, ackValid: 1'b0, flush: 1'b0,
                  expValid: 1'b0, expAddr: 32'h0, expBusy: 1'b1};
    setAccess(0, 1'b1, 32'h1000);
    setAccess(1, 1'b1, 32'h1040);
    setExp(2, 32'h1080);
    vecs[6].ackValid = 1'b1;
    setExp(7, 32'h10C0);
    vecs[11].ackValid = 1'b1;
    setExp(12, 32'h1100);
    vecs[16].ackValid = 1'b1;
    setExp(17, 32'h1140);
    vecs[21].ackValid = 1'b1;
    setAccess(24, 1'b0, 32'h1080);
    setExp(24, 32'h1180);
    vecs[26].flush = 1'b1;
    vecs[28].ackValid = 1'b1;
    for (int i = 26; i < NUM_VECS; i++) vecs[i].expBusy = 1'b0;

    rst = 1'b1;
    resetDut();
    checkOutput("reset valid", 32'(pf.valid), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset statIssued", statIssued, 32'd0);

    for (int i = 0; i < NUM_VECS; i++) begin
      applyStimulus(vecs[i].accValid, vecs[i].accMiss, vecs[i].accAddr, 1'b1,
                    vecs[i].ackValid, 1'b0, vecs[i].flush);
      checkOutput($sformatf("vec%0d valid", i), 32'(pf.valid), 32'(vecs[i].expValid));
      if (vecs[i].expValid) checkOutput($sformatf("vec%0d addr", i), pf.addr, vecs[i].expAddr);
      checkOutput($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].expBusy));
    end
    checkOutput("stream statIssued", statIssued, expStat(5));
    checkOutput("stream statExisting", statExisting, expStat(0));

    // Dropped request: timeout at accept+8, reissue, then a second drop abandons.
    resetDut();
    missAt(32'h1000);
    missAt(32'h1040);
    waitValid("retry first", 32'h1080);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(7);
    checkOutput("timeout not early", statTimeout, expStat(0));
    checkOutput("no reissue early", 32'(pf.valid), 32'd0);
    idle(1);
    checkOutput("timeout count 1", statTimeout, expStat(1));
    checkOutput("busy after timeout", 32'(busy), 32'd1);
    checkOutput("valid right after timeout", 32'(pf.valid), 32'd0);
    idle(1);
    checkOutput("reissue valid", 32'(pf.valid), 32'd1);
    checkOutput("reissue addr", pf.addr, 32'h1080);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(7);
    checkOutput("busy before second timeout", 32'(busy), 32'd1);
    idle(1);
    checkOutput("busy after second timeout", 32'(busy), 32'd0);
    checkOutput("timeout count 2", statTimeout, expStat(2));
    checkOutput("retry statIssued", statIssued, expStat(2));

    // Four consecutive existing acks abandon the stream.
    resetDut();
    missAt(32'h1000);
    missAt(32'h1040);
    doRequest("useless0", 32'h1080, 1'b1, 1'b1);
    doRequest("useless1", 32'h10C0, 1'b1, 1'b1);
    doRequest("useless2", 32'h1100, 1'b1, 1'b1);
    checkOutput("busy after 3 useless", 32'(busy), 32'd1);
    doRequest("useless3", 32'h1140, 1'b1, 1'b1);
    checkOutput("busy after 4 useless", 32'(busy), 32'd0);
    checkOutput("useless statExisting", statExisting, expStat(4));

    // Stream whose first prefetch would leave the page.
    resetDut();
    missAt(32'h1F80);
    missAt(32'h1FC0);
    checkOutput("page issue busy", 32'(busy), 32'd1);
    idle(1);
    checkOutput("page bound busy", 32'(busy), 32'd0);
    checkOutput("page bound valid", 32'(pf.valid), 32'd0);
    idle(2);
    checkOutput("page bound still quiet", 32'(pf.valid), 32'd0);

    // Off-stream miss while waiting, late ack ignored, then flush racing an ack.
    resetDut();
    missAt(32'h1000);
    missAt(32'h1040);
    waitValid("retrain first", 32'h1080);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    missAt(32'h8000);
    checkOutput("retrain busy", 32'(busy), 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("late ack valid", 32'(pf.valid), 32'd0);
    idle(1);
    checkOutput("late ack still quiet", 32'(pf.valid), 32'd0);
    checkOutput("late ack busy", 32'(busy), 32'd1);
    missAt(32'h8040);
    waitValid("retrained stream", 32'h8080);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("flush+ack busy", 32'(busy), 32'd0);
    checkOutput("flush+ack valid", 32'(pf.valid), 32'd0);
    checkOutput("flush+ack statExisting", statExisting, expStat(0));
    checkOutput("retrain statIssued", statIssued, expStat(2));

    // Reset while a request is presented but not accepted.
    resetDut();
    missAt(32'h1000);
    missAt(32'h1040);
    doRequest("pre-reset", 32'h1080, 1'b1, 1'b1);
    waitValid("held request", 32'h10C0);
    checkOutput("pre-reset statIssued", statIssued, expStat(1));
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    checkOutput("mid reset valid", 32'(pf.valid), 32'd0);
    checkOutput("mid reset busy", 32'(busy), 32'd0);
    checkOutput("mid reset statIssued", statIssued, 32'd0);
    checkOutput("mid reset statExisting", statExisting, 32'd0);
    checkOutput("mid reset statTimeout", statTimeout, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
